// File: rtl/next_pc_unit.sv
// next_pc_unit -- program-counter register, next-PC selection and an optional
// return-address stack (RAS).
//
// Optional feature: define NEXT_PC_UNIT_RAS_EN to build the RAS. Without it,
// PCSrc 11 falls back to PC+4, Push is ignored, RasEmpty is 1 and RasFull is 0.
//
// Parameters
//   XLEN         datapath width
//   RESET_VECTOR PC value after reset
//   RAS_DEPTH    number of RAS entries (power of two, 2..16)
//
// Ports
//   clk        clock, all state on the rising edge
//   reset      synchronous active-high reset
//   Stall      hold PC and RAS; clears Misaligned
//   PCSrc      00 PC+4, 01 PC+ImmExt, 10 JALR target, 11 RAS return
//   ImmExt     sign-extended immediate
//   ALUResult  JALR base+offset sum
//   Push       current instruction is a call; push PC+4
//   PC         registered program counter
//   PCPlus4    combinational PC+4
//   PCTarget   combinational PC+ImmExt
//   PCNext     combinational selected next PC
//   Misaligned registered flag, 1 for one cycle after a rejected redirect
//   RasEmpty   RAS occupancy is zero
//   RasFull    RAS occupancy equals RAS_DEPTH
module next_pc_unit #(
   parameter int                XLEN         = 32,
   parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
   parameter int                RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Stall,
   input  logic [1:0]      PCSrc,
   input  logic [XLEN-1:0] ImmExt,
   input  logic [XLEN-1:0] ALUResult,
   input  logic            Push,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PCPlus4,
   output logic [XLEN-1:0] PCTarget,
   output logic [XLEN-1:0] PCNext,
   output logic            Misaligned,
   output logic            RasEmpty,
   output logic            RasFull
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            mis_q, mis_d;
   logic [XLEN-1:0] jalr_tgt;
   logic            ret_valid;   // RAS holds a usable return address
   logic [XLEN-1:0] ret_addr;
   logic            reject;      // redirect to a non-word-aligned target
   logic            pc_upd;      // PC actually advances this cycle

   // Bit 0 of the JALR sum is always cleared, so it never reaches the datapath.
   logic unused_alu_bit0;
   assign unused_alu_bit0 = ALUResult[0];

   // Address arithmetic wraps modulo 2^XLEN; carries are dropped.
   assign PCPlus4  = pc_q + XLEN'(4);
   assign PCTarget = pc_q + ImmExt;
   assign jalr_tgt = {ALUResult[XLEN-1:1], 1'b0};

   always_comb begin
      PCNext = PCPlus4;
      case (PCSrc)
         2'b00: PCNext = PCPlus4;
         2'b01: PCNext = PCTarget;
         2'b10: PCNext = jalr_tgt;
         2'b11: PCNext = ret_valid ? ret_addr : PCPlus4;
         default: PCNext = PCPlus4;
      endcase
   end

   // Only redirects are checked; sequential flow cannot leave word alignment.
   assign reject = (PCSrc != 2'b00) && (PCNext[1:0] != 2'b00);
   assign pc_upd = !Stall && !reject;

   always_comb begin
      pc_d  = pc_q;
      mis_d = 1'b0;
      if (!Stall) begin
         if (reject) mis_d = 1'b1;
         else        pc_d  = PCNext;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_VECTOR;
         mis_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         mis_q <= mis_d;
      end
   end

   assign PC         = pc_q;
   assign Misaligned = mis_q;

`ifdef NEXT_PC_UNIT_RAS_EN
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = PW + 1;

   // Circular buffer: ptr_q indexes the current top entry. When full, a push
   // wraps onto the oldest entry, so the stack keeps the most recent calls.
   logic [XLEN-1:0] ras_q [RAS_DEPTH];
   logic [PW-1:0]   ptr_q, ptr_d, wr_ptr;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wr_en;

   assign ret_valid = (cnt_q != '0);
   assign ret_addr  = ras_q[ptr_q];

   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_ptr = ptr_q;
      if (pc_upd) begin
         if (Push && (PCSrc == 2'b11) && ret_valid) begin
            // Call-and-return in one instruction: swap the top in place.
            wr_en  = 1'b1;
            wr_ptr = ptr_q;
         end else if (Push) begin
            wr_en  = 1'b1;
            wr_ptr = ptr_q + 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
         end else if ((PCSrc == 2'b11) && ret_valid) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage carries no reset; stale contents are hidden while count is 0.
   always_ff @(posedge clk) begin
      if (!reset && wr_en) ras_q[wr_ptr] <= PCPlus4;
   end

   assign RasEmpty = (cnt_q == '0);
   assign RasFull  = (cnt_q == CW'(RAS_DEPTH));
`else
   logic unused_push;
   logic unused_upd;
   assign unused_push = Push;
   assign unused_upd  = pc_upd;
   assign ret_valid   = 1'b0;
   assign ret_addr    = '0;
   assign RasEmpty    = 1'b1;
   assign RasFull     = 1'b0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;

   localparam int RAS_DEPTH = 4;
`ifdef NEXT_PC_UNIT_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, Stall, Push;
   logic [1:0]  PCSrc;
   logic [31:0] ImmExt, ALUResult;
   logic [31:0] PC, PCPlus4, PCTarget, PCNext;
   logic        Misaligned, RasEmpty, RasFull;

   next_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .RAS_DEPTH(RAS_DEPTH)) dut (
      .clk(clk), .reset(reset), .Stall(Stall), .PCSrc(PCSrc), .ImmExt(ImmExt),
      .ALUResult(ALUResult), .Push(Push), .PC(PC), .PCPlus4(PCPlus4),
      .PCTarget(PCTarget), .PCNext(PCNext), .Misaligned(Misaligned),
      .RasEmpty(RasEmpty), .RasFull(RasFull)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: PC, flag, and the return stack as a bounded queue
   // (newest at the back; the oldest falls off the front when over capacity).
   logic [31:0] m_pc;
   logic        m_mis;
   logic        m_valid = 1'b0;
   logic [31:0] m_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic st, input logic [1:0] src,
                       input logic [31:0] imm, input logic [31:0] alu, input logic psh);
      logic [31:0] p4, tgt, nxt;
      logic        has_ret, rej;
      reset = rst; Stall = st; PCSrc = src; ImmExt = imm; ALUResult = alu; Push = psh;
      #1;
      p4      = m_pc + 32'd4;
      tgt     = m_pc + imm;
      has_ret = RAS_EN && (m_q.size() > 0);
      case (src)
         2'd0: nxt = p4;
         2'd1: nxt = tgt;
         2'd2: nxt = alu & 32'hFFFF_FFFE;
         default: nxt = has_ret ? m_q[m_q.size()-1] : p4;
      endcase
      rej = (src != 2'd0) && (nxt % 4 != 0);
      if (m_valid) begin
         chk("PCPlus4", PCPlus4, p4);
         chk("PCTarget", PCTarget, tgt);
         chk("PCNext", PCNext, nxt);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         m_pc = 32'h0; m_mis = 1'b0; m_q.delete(); m_valid = 1'b1;
      end else if (st) begin
         m_mis = 1'b0;
      end else if (rej) begin
         m_mis = 1'b1;
      end else begin
         m_pc = nxt; m_mis = 1'b0;
         if (RAS_EN) begin
            if (psh && src == 2'd3 && has_ret) m_q[m_q.size()-1] = p4;
            else if (psh) begin
               m_q.push_back(p4);
               if (m_q.size() > RAS_DEPTH) void'(m_q.pop_front());
            end else if (src == 2'd3 && has_ret) void'(m_q.pop_back());
         end
      end
      if (m_valid) begin
         chk("PC", PC, m_pc);
         chk("Misaligned", {31'd0, Misaligned}, {31'd0, m_mis});
         chk("RasEmpty", {31'd0, RasEmpty}, {31'd0, (m_q.size() == 0)});
         chk("RasFull", {31'd0, RasFull}, {31'd0, (m_q.size() == RAS_DEPTH)});
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; Stall = 1'b0; Push = 1'b0; PCSrc = 2'd0; ImmExt = '0; ALUResult = '0;
      @(negedge clk);

      // Reset (with distracting controls) then sequential flow
      step(1, 1, 2'd3, 32'h0, 32'h0, 1);
      chk("reset_pc", PC, 32'h0);
      step(0, 0, 2'd0, 32'h0, 32'h0, 0); chk("seq_4", PC, 32'h4);
      step(0, 0, 2'd0, 32'h0, 32'h0, 0); chk("seq_8", PC, 32'h8);
      step(0, 0, 2'd0, 32'h0, 32'h0, 0); chk("seq_c", PC, 32'hC);

      // Branch with negative offset, then wrap at the top of the address space
      step(0, 0, 2'd2, 32'h0, 32'h100, 0);
      step(0, 0, 2'd1, 32'hFFFF_FFF0, 32'h0, 0); chk("br_neg", PC, 32'hF0);
      step(0, 0, 2'd2, 32'h0, 32'hFFFF_FFFC, 0);
      step(0, 0, 2'd0, 32'h0, 32'h0, 0); chk("wrap", PC, 32'h0);

      // Misaligned JALR rejected, then an aligned one accepted
      step(0, 0, 2'd2, 32'h0, 32'h20, 0);
      step(0, 0, 2'd2, 32'h0, 32'h47, 0);
      chk("mis_hold", PC, 32'h20);
      chk("mis_flag", {31'd0, Misaligned}, 32'd1);
      step(0, 0, 2'd2, 32'h0, 32'h45, 0);
      chk("jalr_ok", PC, 32'h44);
      chk("mis_clr", {31'd0, Misaligned}, 32'd0);

      // Stall clears the flag and holds everything
      step(0, 0, 2'd1, 32'h2, 32'h0, 0);
      step(0, 1, 2'd3, 32'h0, 32'h0, 1);
      chk("stall_pc", PC, 32'h44);
      chk("stall_mis", {31'd0, Misaligned}, 32'd0);

`ifdef NEXT_PC_UNIT_RAS_EN
      // Five calls into a four-deep stack, then five returns
      step(1, 0, 2'd0, 32'h0, 32'h0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 2'd2, 32'h0, 32'h10 * (i + 1), 1);
         if (i == 3) chk("ras_full", {31'd0, RasFull}, 32'd1);
      end
      step(0, 0, 2'd3, 32'h0, 32'h0, 0); chk("ret0", PC, 32'h44);
      step(0, 0, 2'd3, 32'h0, 32'h0, 0); chk("ret1", PC, 32'h34);
      step(0, 0, 2'd3, 32'h0, 32'h0, 0); chk("ret2", PC, 32'h24);
      step(0, 0, 2'd3, 32'h0, 32'h0, 0); chk("ret3", PC, 32'h14);
      chk("ras_empty", {31'd0, RasEmpty}, 32'd1);
      step(0, 0, 2'd3, 32'h0, 32'h0, 0); chk("ret_empty", PC, 32'h18);

      // Stall during push+return, then swap-top call/return
      step(1, 0, 2'd0, 32'h0, 32'h0, 0);
      step(0, 0, 2'd2, 32'h0, 32'h10, 1);
      step(0, 0, 2'd2, 32'h0, 32'h80, 1);
      step(0, 1, 2'd3, 32'h0, 32'h0, 1); chk("stall_ras", PC, 32'h80);
      step(0, 0, 2'd3, 32'h0, 32'h0, 1); chk("swap_pc", PC, 32'h14);
      step(0, 0, 2'd3, 32'h0, 32'h0, 0); chk("swap_top", PC, 32'h84);
      step(0, 0, 2'd3, 32'h0, 32'h0, 0); chk("swap_old", PC, 32'h4);
`else
      step(1, 0, 2'd0, 32'h0, 32'h0, 0);
      step(0, 0, 2'd2, 32'h0, 32'h8, 1);
      step(0, 0, 2'd3, 32'h0, 32'h0, 1);
      chk("noras_ret", PC, 32'hC);
      chk("noras_empty", {31'd0, RasEmpty}, 32'd1);
      chk("noras_full", {31'd0, RasFull}, 32'd0);
`endif

      // Randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         logic [31:0] imm, alu;
         imm = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         alu = $urandom;
         step($urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0,
              2'($urandom_range(0, 3)), imm, alu, $urandom_range(0, 2) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value after reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, 2..16.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Stall  input  1  hold PC and RAS when high.
REQ-007 SHALL have port PCSrc  input  2  00 sequential, 01 PC+ImmExt, 10 JALR (ALUResult with bit0 cleared), 11 RAS return.
REQ-008 SHALL have port ImmExt  input  XLEN  sign-extended immediate.
REQ-009 SHALL have port ALUResult  input  XLEN  JALR base+offset sum.
REQ-010 SHALL have port Push  input  1  current instruction is a call; push PCPlus4.
REQ-011 SHALL have port PC  output  XLEN  registered program counter.
REQ-012 SHALL have ports PCPlus4 and PCTarget  output  XLEN  combinational PC+4 and PC+ImmExt.
REQ-013 SHALL have port PCNext  output  XLEN  combinational selected next PC.
REQ-014 SHALL have port Misaligned  output  1  registered; rejected-redirect flag.
REQ-015 SHALL have ports RasEmpty and RasFull  output  1  combinational from occupancy count.

Function
REQ-016 PCPlus4, PCTarget and the JALR target SHALL be computed modulo 2^XLEN; carry out discarded.
REQ-017 PCNext SHALL be PCPlus4 / PCTarget / {ALUResult[XLEN-1:1],1'b0} / RAS top for PCSrc 00/01/10/11.
REQ-018 PCSrc 11 with RAS empty SHALL select PCPlus4.
REQ-019 With Stall low, PC SHALL load PCNext on the rising edge (one-cycle latency), unless REQ-020 applies.
REQ-020 If PCSrc != 00 and PCNext[1:0] != 2'b00, PC SHALL hold, and Misaligned SHALL be 1 in the following cycle only.
REQ-021 Stall high SHALL hold PC, RAS contents and count, and SHALL clear Misaligned next cycle.
REQ-022 RAS pointer SHALL advance only on a cycle where PC actually updates.
REQ-023 Push alone SHALL write PCPlus4 above top; count increments, saturating at RAS_DEPTH.
REQ-024 Push when full SHALL overwrite the oldest entry (circular pointer wrap); RasFull stays 1.
REQ-025 PCSrc 11 alone with count > 0 SHALL pop: count decrements, pointer moves down with wrap.
REQ-026 PCSrc 11 with empty RAS SHALL leave count at 0; pointer unchanged.
REQ-027 Push with PCSrc 11 same cycle SHALL redirect to old top and replace top with PCPlus4; count unchanged (if empty: acts as plain push).
REQ-028 RasEmpty SHALL equal (count == 0); RasFull SHALL equal (count == RAS_DEPTH).

Reset
REQ-029 reset high at a rising edge SHALL set PC = RESET_VECTOR, Misaligned = 0, RAS count and pointer = 0, regardless of Stall, Push, PCSrc.
REQ-030 RAS entry contents SHALL not require reset; they are not observable while count is 0.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight push/pop of that cycle.

Configuration
REQ-032 Macro NEXT_PC_UNIT_RAS_EN defined SHALL include the RAS per REQ-023..REQ-028.
REQ-033 Macro undefined SHALL remove all RAS storage: PCSrc 11 selects PCPlus4, Push ignored, RasEmpty tied 1, RasFull tied 0.

Verification
REQ-034 Reset release, PCSrc 00, 3 cycles -> PC 0x0, 0x4, 0x8, 0xC.
REQ-035 PC 0x100, PCSrc 01, ImmExt 0xFFFF_FFF0 -> PC 0xF0; PC 0xFFFF_FFFC, PCSrc 00 -> PC 0x0 (wrap).
REQ-036 PC 0x20, PCSrc 10, ALUResult 0x47 -> PC 0x46? rejected (bit1 set): PC holds 0x20, Misaligned 1 for one cycle; ALUResult 0x45 -> PC 0x44.
REQ-037 RAS_EN, depth 4: 5 pushes from PCs 0x0,0x10,0x20,0x30,0x40 then 5 returns -> targets 0x44,0x34,0x24,0x14, then PCPlus4; RasFull 1 after push 4, RasEmpty 1 after return 4.
REQ-038 Stall high during Push and PCSrc 11 -> PC, count, Misaligned(0) unchanged; simultaneous Push+return with top 0x14 at PC 0x80 -> PC 0x14, top becomes 0x84, count unchanged.
REQ-039 Macro undefined: PCSrc 11 at PC 0x8 -> PC 0xC; RasEmpty 1, RasFull 0.
